register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp.sv | 67 ++++++
 tb/tb_register_file_mp.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp: 2-write / NREAD-read register file with a per-register pending scoreboard.
// Optional RF_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module register_file_mp #(
  parameter int WIDTH     = 32,
  parameter int REGISTERS = 32,
  parameter int NREAD     = 2,
  localparam int AW       = $clog2(REGISTERS),
  localparam int CW       = $clog2(REGISTERS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   flush,
  output logic [NREAD-1:0]       busy,
  output logic [CW-1:0]          pend_cnt
);
  logic [WIDTH-1:0]     r_mem [REGISTERS];
  logic [REGISTERS-1:0] r_pend;
  logic [REGISTERS-1:0] w_clr, w_set, w_pend_nxt;
  logic [CW-1:0]        w_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < REGISTERS; r++) r_mem[r] <= '0;
      r_pend <= '0;
    end else begin
      if (we0 && wa0 != '0) r_mem[wa0] <= wd0;
      if (we1 && wa1 != '0) r_mem[wa1] <= wd1;
      r_pend <= w_pend_nxt;
    end
  // A same-cycle issue overrides both flush and write-back clears; register 0 is never pending.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (we0) w_clr[wa0] = 1'b1;
    if (we1) w_clr[wa1] = 1'b1;
    if (iss_valid) w_set[iss_rd] = 1'b1;
    w_pend_nxt = (((flush ? '0 : r_pend) & ~w_clr) | w_set) & {{(REGISTERS-1){1'b1}}, 1'b0};
  end
  always_comb begin
    w_cnt = '0;
    for (int r = 0; r < REGISTERS; r++) w_cnt = w_cnt + CW'(r_pend[r]);
  end
  assign pend_cnt = w_cnt;
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = ra[i*AW +: AW];
`ifdef RF_BYPASS_EN
    logic w_h0, w_h1;
    assign w_h0 = rst_n && we0 && wa0 != '0 && wa0 == w_a;
    assign w_h1 = rst_n && we1 && wa1 != '0 && wa1 == w_a;
    assign rd[i*WIDTH +: WIDTH] = w_h1 ? wd1 : w_h0 ? wd0 : r_mem[w_a];
    assign busy[i] = r_pend[w_a] && !(w_h0 || w_h1);
`else
    assign rd[i*WIDTH +: WIDTH] = r_mem[w_a];
    assign busy[i] = r_pend[w_a];
`endif
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed scoreboard bench for register_file_mp (default 32x32, 2 read ports).
module tb_register_file_mp;
  localparam int W = 32, R = 32, N = 2, AW = 5, CW = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic we0 = 0, we1 = 0, iss_valid = 0, flush = 0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, iss_rd = '0;
  logic [W-1:0] wd0 = '0, wd1 = '0;
  logic [N*AW-1:0] ra = '0;
  logic [N*W-1:0] rd;
  logic [N-1:0] busy;
  logic [CW-1:0] pend_cnt;
  int n_cmp = 0, n_err = 0;
  string sb_tag [$];
  logic [W-1:0] sb_val [$];

  register_file_mp #(.WIDTH(W), .REGISTERS(R), .NREAD(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .busy(busy), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [W-1:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic sb_check(input logic [W-1:0] obs);
    string t;
    logic [W-1:0] e;
    n_cmp++;
    if (sb_val.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      t = sb_tag.pop_front();
      e = sb_val.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  function automatic logic [W-1:0] rdp(input int p);
    return rd[p*W +: W];
  endfunction

  task automatic idle;
    we0 = 0; we1 = 0; iss_valid = 0; flush = 0;
  endtask

  initial begin
    // Reset: every address reads 0, nothing busy
    #2;
    sb_push("rst_cnt", 0); sb_check(W'(pend_cnt));
    for (int a = 0; a < R; a++) begin
      set_ra(0, AW'(a)); set_ra(1, AW'(R - 1 - a));
      #1;
      sb_push("rst_rd0", 0); sb_check(rdp(0));
      sb_push("rst_rd1", 0); sb_check(rdp(1));
      sb_push("rst_busy", 0); sb_check(W'(busy));
    end
    tick;
    rst_n = 1;
    // Single write, then visible next cycle
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; set_ra(0, 5);
`ifndef RF_BYPASS_EN
    #1; sb_push("wr5_before_edge", 0); sb_check(rdp(0));
`endif
    tick; idle;
    #1; sb_push("wr5", 32'hDEADBEEF); sb_check(rdp(0));
    // Write to register 0 is discarded
    we1 = 1; wa1 = 0; wd1 = 32'h1234; set_ra(1, 0);
    tick; idle;
    #1; sb_push("wr0_discard", 0); sb_check(rdp(1));
    sb_push("wr0_nopend", 0); sb_check(W'(pend_cnt));
    // Dual write same address: port 1 wins
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    tick; idle;
    set_ra(0, 7); set_ra(1, 5);
    #1; sb_push("dual_wr7", 32'h22); sb_check(rdp(0));
    sb_push("keep5", 32'hDEADBEEF); sb_check(rdp(1));
    // Issue 3 then 9
    iss_valid = 1; iss_rd = 3; tick;
    iss_rd = 9; tick; idle;
    set_ra(0, 3); set_ra(1, 0);
    #1; sb_push("pend2", 2); sb_check(W'(pend_cnt));
    sb_push("busy3", 2'b01); sb_check(W'(busy));
    // Issue to register 0 never pends
    iss_valid = 1; iss_rd = 0; tick; idle;
    #1; sb_push("iss0_ignored", 2); sb_check(W'(pend_cnt));
    // Write-back clears 3
    we0 = 1; wa0 = 3; wd0 = 32'h3333; tick; idle;
    #1; sb_push("wb3_cnt", 1); sb_check(W'(pend_cnt));
    sb_push("wb3_busy", 0); sb_check(W'(busy));
    sb_push("wb3_data", 32'h3333); sb_check(rdp(0));
    // Issue and write 9 together: set wins
    iss_valid = 1; iss_rd = 9; we1 = 1; wa1 = 9; wd1 = 32'h9999; tick; idle;
    set_ra(1, 9);
    #1; sb_push("setwins_cnt", 1); sb_check(W'(pend_cnt));
    sb_push("setwins_busy", 2'b10); sb_check(W'(busy));
    sb_push("setwins_data", 32'h9999); sb_check(rdp(1));
    // Flush clears, contents intact
    flush = 1; tick; idle;
    #1; sb_push("flush_cnt", 0); sb_check(W'(pend_cnt));
    sb_push("flush_data", 32'h9999); sb_check(rdp(1));
    // Forwarding case: register 4 pending, written while read
    we0 = 1; wa0 = 4; wd0 = 32'h1111; tick; idle;
    iss_valid = 1; iss_rd = 4; tick; idle;
    set_ra(1, 4); we1 = 1; wa1 = 4; wd1 = 32'hA5A5A5A5;
    #1;
`ifdef RF_BYPASS_EN
    sb_push("byp_rd1", 32'hA5A5A5A5); sb_check(rdp(1));
    sb_push("byp_busy1", 0); sb_check(W'(busy[1]));
`else
    sb_push("nobyp_rd1", 32'h1111); sb_check(rdp(1));
    sb_push("nobyp_busy1", 1); sb_check(W'(busy[1]));
`endif
    tick; idle;
    #1; sb_push("byp_after_rd1", 32'hA5A5A5A5); sb_check(rdp(1));
    sb_push("byp_after_cnt", 0); sb_check(W'(pend_cnt));
    // Flush with simultaneous issue: only issued register remains
    iss_valid = 1; iss_rd = 3; tick;
    iss_rd = 5; tick;
    iss_rd = 9; flush = 1; tick; idle;
    set_ra(0, 9); set_ra(1, 3);
    #1; sb_push("flushiss_cnt", 1); sb_check(W'(pend_cnt));
    sb_push("flushiss_busy", 2'b01); sb_check(W'(busy));
    // Three pending, then asynchronous reset mid-cycle
    iss_valid = 1; iss_rd = 10; tick;
    iss_rd = 11; tick; idle;
    #1; sb_push("pre_rst_cnt", 3); sb_check(W'(pend_cnt));
    set_ra(0, 5); set_ra(1, 10);
    we0 = 1; wa0 = 12; wd0 = 32'hBAD0BAD0; iss_valid = 1; iss_rd = 12;
    #1; rst_n = 0;
    #1; sb_push("arst_cnt", 0); sb_check(W'(pend_cnt));
    sb_push("arst_rd0", 0); sb_check(rdp(0));
    sb_push("arst_busy", 0); sb_check(W'(busy));
    tick;
    #1; sb_push("arst_edge_cnt", 0); sb_check(W'(pend_cnt));
    set_ra(1, 12);
    #1; sb_push("arst_edge_rd12", 0); sb_check(rdp(1));
    idle;
    #1; rst_n = 1;
    #1; sb_push("rel_cnt", 0); sb_check(W'(pend_cnt));
    sb_push("rel_rd5", 0); sb_check(rdp(0));
    // First edge after release behaves normally
    we0 = 1; wa0 = 6; wd0 = 32'h600D600D; iss_valid = 1; iss_rd = 12; tick; idle;
    set_ra(0, 6);
    #1; sb_push("post_rst_wr6", 32'h600D600D); sb_check(rdp(0));
    sb_push("post_rst_cnt", 1); sb_check(W'(pend_cnt));
    sb_push("post_rst_busy", 2'b10); sb_check(W'(busy));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
